// File: rtl/time_set_ctrl.sv
// Clock time-setting controller: debounced-edge buttons drive a RUN/SET_H/SET_M/COMMIT
// editor that works on shadow copies of the live hours/minutes and loads them back on commit.
module time_set_ctrl (
  input  logic       maqh_clock,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [2:0] cur_h_msd,
  input  logic [3:0] cur_h_lsd,
  input  logic [2:0] cur_m_msd,
  input  logic [3:0] cur_m_lsd,
  output logic       run_en,
  output logic       load,
  output logic [2:0] ld_h_msd,
  output logic [3:0] ld_h_lsd,
  output logic [2:0] ld_m_msd,
  output logic [3:0] ld_m_lsd,
  output logic       blank_h,
  output logic       blank_m,
  output logic [1:0] mode
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] SET_H  = 2'd1;
  localparam logic [1:0] SET_M  = 2'd2;
  localparam logic [1:0] COMMIT = 2'd3;

  logic [1:0] btn_raw;
  logic [1:0] pulse;
  logic [1:0] valid_reg;
  logic       p_mode;
  logic       p_inc;

  assign btn_raw = {btn_inc, btn_mode};
  assign p_mode  = pulse[0];
  assign p_inc   = pulse[1];

  // valid_reg[1] marks that the synchronizer outputs reflect post-reset samples
  always_ff @(posedge maqh_clock or negedge reset) begin
    if (!reset) valid_reg <= 2'b00;
    else        valid_reg <= {valid_reg[0], 1'b1};
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic sync1_reg;
      logic sync2_reg;
      logic prev_reg;
      logic armed_reg;

      // armed only after the button is seen low, so a press held across reset is ignored
      always_ff @(posedge maqh_clock or negedge reset) begin
        if (!reset) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          prev_reg  <= 1'b0;
          armed_reg <= 1'b0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          prev_reg  <= sync2_reg;
          armed_reg <= armed_reg | (valid_reg[1] & ~sync2_reg);
        end
      end

      assign pulse[gi] = sync2_reg & ~prev_reg & armed_reg;
    end
  endgenerate

  logic [1:0] state_reg, state_next;
  logic [3:0] tcnt_reg, tcnt_next;
  logic       blink_reg, blink_next;
  logic [2:0] h_msd_reg, h_msd_next, m_msd_reg, m_msd_next;
  logic [3:0] h_lsd_reg, h_lsd_next, m_lsd_reg, m_lsd_next;

  always_comb begin
    state_next = state_reg;
    tcnt_next  = tcnt_reg;
    blink_next = 1'b0;
    h_msd_next = h_msd_reg;
    h_lsd_next = h_lsd_reg;
    m_msd_next = m_msd_reg;
    m_lsd_next = m_lsd_reg;
    case (state_reg)
      RUN: begin
        tcnt_next = 4'd0;
        if (p_mode) begin
          state_next = SET_H;
          h_msd_next = cur_h_msd;
          h_lsd_next = cur_h_lsd;
          m_msd_next = cur_m_msd;
          m_lsd_next = cur_m_lsd;
        end
      end
      SET_H, SET_M: begin
        if (p_mode) begin
          state_next = (state_reg == SET_H) ? SET_M : COMMIT;
          tcnt_next  = 4'd0;
        end else if (p_inc) begin
          tcnt_next = 4'd0;
          if (state_reg == SET_H) begin
            // out-of-range or 23 wraps to 00
            if (h_msd_reg > 3'd2 || h_lsd_reg > 4'd9 || (h_msd_reg == 3'd2 && h_lsd_reg >= 4'd3)) begin
              h_msd_next = 3'd0;
              h_lsd_next = 4'd0;
            end else if (h_lsd_reg == 4'd9) begin
              h_msd_next = h_msd_reg + 3'd1;
              h_lsd_next = 4'd0;
            end else begin
              h_lsd_next = h_lsd_reg + 4'd1;
            end
          end else begin
            if (m_msd_reg > 3'd5 || m_lsd_reg > 4'd9 || (m_msd_reg == 3'd5 && m_lsd_reg == 4'd9)) begin
              m_msd_next = 3'd0;
              m_lsd_next = 4'd0;
            end else if (m_lsd_reg == 4'd9) begin
              m_msd_next = m_msd_reg + 3'd1;
              m_lsd_next = 4'd0;
            end else begin
              m_lsd_next = m_lsd_reg + 4'd1;
            end
          end
        end else if (tick_1hz) begin
          if (tcnt_reg == 4'd9) begin
            state_next = RUN;
            tcnt_next  = 4'd0;
          end else begin
            tcnt_next = tcnt_reg + 4'd1;
          end
        end
        if (state_next == SET_H || state_next == SET_M) blink_next = blink_reg ^ tick_1hz;
      end
      default: begin
        state_next = RUN;
        tcnt_next  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge maqh_clock or negedge reset) begin
    if (!reset) begin
      state_reg <= RUN;
      tcnt_reg  <= 4'd0;
      blink_reg <= 1'b0;
      h_msd_reg <= 3'd0;
      h_lsd_reg <= 4'd0;
      m_msd_reg <= 3'd0;
      m_lsd_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      tcnt_reg  <= tcnt_next;
      blink_reg <= blink_next;
      h_msd_reg <= h_msd_next;
      h_lsd_reg <= h_lsd_next;
      m_msd_reg <= m_msd_next;
      m_lsd_reg <= m_lsd_next;
    end
  end

  assign mode     = state_reg;
  assign run_en   = (state_reg == RUN);
  assign load     = (state_reg == COMMIT);
  assign blank_h  = (state_reg == SET_H) & blink_reg;
  assign blank_m  = (state_reg == SET_M) & blink_reg;
  assign ld_h_msd = h_msd_reg;
  assign ld_h_lsd = h_lsd_reg;
  assign ld_m_msd = m_msd_reg;
  assign ld_m_lsd = m_lsd_reg;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios plus random stimulus, all checked every
// cycle against a sample-history/arithmetic reference model of the editor.
module tb_time_set_ctrl;

  logic       maqh_clock = 1'b0;
  logic       reset = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [2:0] cur_h_msd = 3'd0;
  logic [3:0] cur_h_lsd = 4'd0;
  logic [2:0] cur_m_msd = 3'd0;
  logic [3:0] cur_m_lsd = 4'd0;
  logic       run_en, load, blank_h, blank_m;
  logic [2:0] ld_h_msd, ld_m_msd;
  logic [3:0] ld_h_lsd, ld_m_lsd;
  logic [1:0] mode;

  time_set_ctrl dut (
    .maqh_clock(maqh_clock), .reset(reset), .tick_1hz(tick_1hz),
    .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_h_msd(cur_h_msd), .cur_h_lsd(cur_h_lsd),
    .cur_m_msd(cur_m_msd), .cur_m_lsd(cur_m_lsd),
    .run_en(run_en), .load(load),
    .ld_h_msd(ld_h_msd), .ld_h_lsd(ld_h_lsd),
    .ld_m_msd(ld_m_msd), .ld_m_lsd(ld_m_lsd),
    .blank_h(blank_h), .blank_m(blank_m), .mode(mode)
  );

  always #5 maqh_clock = ~maqh_clock;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0..3, shadow time as digit pairs, seconds-without-button count
  int m_mode = 0, m_hm = 0, m_hl = 0, m_mm = 0, m_ml = 0, m_idle = 0, m_blink = 0;
  int m_edges = 0;
  int bm1 = 0, bm2 = 0, bm3 = 0, bi1 = 0, bi2 = 0, bi3 = 0;
  int pm, pi, v, nxt_mode;

  always @(posedge maqh_clock or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_hm = 0; m_hl = 0; m_mm = 0; m_ml = 0; m_idle = 0; m_blink = 0;
      m_edges = 0; bm1 = 0; bm2 = 0; bm3 = 0; bi1 = 0; bi2 = 0; bi3 = 0;
    end else begin
      m_edges++;
      // a button first sampled high at edge k (low at k-1) acts at edge k+2
      pm = (m_edges >= 4 && bm2 == 1 && bm3 == 0) ? 1 : 0;
      pi = (m_edges >= 4 && bi2 == 1 && bi3 == 0) ? 1 : 0;
      bm3 = bm2; bm2 = bm1; bm1 = int'(btn_mode);
      bi3 = bi2; bi2 = bi1; bi1 = int'(btn_inc);
      nxt_mode = m_mode;
      if (m_mode == 0) begin
        m_idle = 0;
        if (pm == 1) begin
          nxt_mode = 1;
          m_hm = cur_h_msd; m_hl = cur_h_lsd; m_mm = cur_m_msd; m_ml = cur_m_lsd;
        end
      end else if (m_mode == 3) begin
        nxt_mode = 0;
        m_idle = 0;
      end else begin
        if (pm == 1) begin
          nxt_mode = m_mode + 1;
          m_idle = 0;
        end else if (pi == 1) begin
          m_idle = 0;
          if (m_mode == 1) begin
            v = m_hm * 10 + m_hl;
            v = (m_hl > 9 || v >= 23) ? 0 : v + 1;
            m_hm = v / 10; m_hl = v % 10;
          end else begin
            v = m_mm * 10 + m_ml;
            v = (m_ml > 9 || v >= 59) ? 0 : v + 1;
            m_mm = v / 10; m_ml = v % 10;
          end
        end else if (tick_1hz) begin
          m_idle++;
          if (m_idle == 10) begin
            nxt_mode = 0;
            m_idle = 0;
          end
        end
      end
      if ((m_mode == 1 || m_mode == 2) && (nxt_mode == 1 || nxt_mode == 2))
        m_blink = m_blink ^ int'(tick_1hz);
      else
        m_blink = 0;
      m_mode = nxt_mode;
    end
  end

  bit chk_en = 1'b0;
  int load_seen = 0;
  logic [13:0] last_ld = '0;

  always @(negedge maqh_clock) begin
    if (chk_en) begin
      chk("mode", int'(mode), m_mode);
      chk("run_en", int'(run_en), (m_mode == 0) ? 1 : 0);
      chk("load", int'(load), (m_mode == 3) ? 1 : 0);
      chk("ld_h", int'(ld_h_msd) * 16 + int'(ld_h_lsd), m_hm * 16 + m_hl);
      chk("ld_m", int'(ld_m_msd) * 16 + int'(ld_m_lsd), m_mm * 16 + m_ml);
      chk("blank_h", int'(blank_h), (m_mode == 1 && m_blink == 1) ? 1 : 0);
      chk("blank_m", int'(blank_m), (m_mode == 2 && m_blink == 1) ? 1 : 0);
      if (load) begin
        load_seen++;
        last_ld = {ld_h_msd, ld_h_lsd, ld_m_msd, ld_m_lsd};
      end
    end
  end

  task automatic nxt(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge maqh_clock);
      #1;
    end
  endtask

  task automatic press(input bit do_mode, input bit do_inc);
    btn_mode = do_mode;
    btn_inc  = do_inc;
    nxt(3);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    nxt(3);
  endtask

  task automatic set_cur(input int h, input int m);
    cur_h_msd = 3'(h / 10); cur_h_lsd = 4'(h % 10);
    cur_m_msd = 3'(m / 10); cur_m_lsd = 4'(m % 10);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1'b1;
      nxt(1);
      tick_1hz = 1'b0;
      nxt(2);
    end
  endtask

  int loads0;

  initial begin
    nxt(3);
    chk_en = 1'b1;
    chk("rst_mode", int'(mode), 0);
    chk("rst_run_en", int'(run_en), 1);
    chk("rst_ld", int'({ld_h_msd, ld_h_lsd, ld_m_msd, ld_m_lsd}), 0);

    // button held across reset release must not act
    btn_mode = 1'b1;
    nxt(1);
    reset = 1'b1;
    nxt(8);
    chk("held_no_pulse", int'(mode), 0);
    btn_mode = 1'b0;
    nxt(4);

    // 13:47 -> 15:48
    set_cur(13, 47);
    loads0 = load_seen;
    press(1, 0);
    chk("entry_mode", int'(mode), 1);
    chk("entry_capture", int'({ld_h_msd, ld_h_lsd, ld_m_msd, ld_m_lsd}), int'({3'd1, 4'd3, 3'd4, 4'd7}));
    press(0, 1); press(0, 1); press(1, 0); press(0, 1); press(1, 0);
    chk("commit_loads", load_seen - loads0, 1);
    chk("commit_ld", int'(last_ld), int'({3'd1, 4'd5, 3'd4, 4'd8}));
    chk("commit_run_en", int'(run_en), 1);

    // 23:59 wraps to 00:00
    set_cur(23, 59);
    press(1, 0); press(0, 1); press(1, 0); press(0, 1); press(1, 0);
    chk("wrap_ld", int'(last_ld), 0);

    // simultaneous mode+inc in SET_H
    set_cur(5, 30);
    press(1, 0);
    press(1, 1);
    chk("simul_mode", int'(mode), 2);
    chk("simul_hour", int'({ld_h_msd, ld_h_lsd}), int'({3'd0, 4'd5}));
    press(1, 0);
    nxt(2);

    // blink and latency in SET_H
    press(1, 0);
    chk("blink_before", int'(blank_h), 0);
    tick_1hz = 1'b1;
    nxt(1);
    tick_1hz = 1'b0;
    chk("blink_after", int'(blank_h), 1);
    chk("blink_m_zero", int'(blank_m), 0);
    btn_mode = 1'b1;
    nxt(1);
    chk("lat_k", int'(mode), 1);
    nxt(1);
    chk("lat_k1", int'(mode), 1);
    nxt(1);
    chk("lat_k2", int'(mode), 2);
    btn_mode = 1'b0;
    nxt(3);

    // timeout in SET_M after 10 ticks, no load
    loads0 = load_seen;
    ticks(9);
    chk("to_before", int'(mode), 2);
    ticks(1);
    chk("to_after", int'(mode), 0);
    chk("to_no_load", load_seen - loads0, 0);

    // inc at tick 9 postpones the timeout
    press(1, 0); press(1, 0);
    ticks(9);
    press(0, 1);
    ticks(9);
    chk("to_postponed", int'(mode), 2);
    ticks(1);
    chk("to_late", int'(mode), 0);
    chk("to_late_no_load", load_seen - loads0, 0);

    // reset mid-edit abandons the edit
    set_cur(10, 20);
    press(1, 0); press(1, 0); press(0, 1); press(0, 1); press(0, 1);
    loads0 = load_seen;
    reset = 1'b0;
    nxt(2);
    chk("rme_mode", int'(mode), 0);
    chk("rme_load", int'(load), 0);
    chk("rme_ld", int'({ld_h_msd, ld_h_lsd, ld_m_msd, ld_m_lsd}), 0);
    chk("rme_blank", int'({blank_h, blank_m}), 0);
    reset = 1'b1;
    nxt(4);
    chk("rme_no_load", load_seen - loads0, 0);

    // random traffic, including illegal captured values and occasional resets
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(0, 2) == 0) btn_inc = ~btn_inc;
      tick_1hz = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) begin
        cur_h_msd = 3'($urandom_range(0, 7)); cur_h_lsd = 4'($urandom_range(0, 15));
        cur_m_msd = 3'($urandom_range(0, 7)); cur_m_lsd = 4'($urandom_range(0, 15));
      end
      reset = ($urandom_range(0, 600) != 0);
      nxt(1);
    end
    reset = 1'b1;
    tick_1hz = 1'b0;
    nxt(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
